// File: rtl/sign_narrow_if.sv
// Stream bundle for sign_narrow: wide input side, narrow output side and saturation status.
interface sign_narrow_if #(
    parameter int unsigned IN_W  = 10,
    parameter int unsigned OUT_W = 6,
    parameter int unsigned CNT_W = 8
);
    logic [IN_W-1:0]  In;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] Out;
    logic             out_valid;
    logic             out_ready;
    logic             sat;
    logic             sat_sticky;
    logic             sat_clr;
    logic [CNT_W-1:0] sat_count;

    // Driver/consumer side: produces input words, accepts narrowed words.
    modport master (
        output In, in_valid, out_ready, sat_clr,
        input  in_ready, Out, out_valid, sat, sat_sticky, sat_count
    );

    // The narrowing block itself.
    modport slave (
        input  In, in_valid, out_ready, sat_clr,
        output in_ready, Out, out_valid, sat, sat_sticky, sat_count
    );
endinterface

// File: rtl/sign_narrow.sv
// Saturating signed narrowing IN_W -> OUT_W in a two-stage valid/ready pipeline,
// with per-word clamp flag, sticky clamp flag and a saturating clamp counter.
module sign_narrow #(
    parameter int unsigned IN_W  = 10,
    parameter int unsigned OUT_W = 6,
    parameter int unsigned CNT_W = 8
) (
    input logic          clk,
    input logic          rst,
    sign_narrow_if.slave bus
);
    localparam logic [OUT_W-1:0] MaxVal = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0] MinVal = {1'b1, {(OUT_W - 1){1'b0}}};
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic             v1_q, hi1_q, lo1_q;
    logic [OUT_W-1:0] d1_q;
    logic             v2_q, sat2_q;
    logic [OUT_W-1:0] out_q;
    logic             sticky_q;
    logic [CNT_W-1:0] cnt_q;

    logic [IN_W-OUT_W:0] top_bits;
    logic                ovf, hi_in, lo_in;
    logic                adv2, in_rdy, in_xfer, sat_xfer;

    // Value fits in OUT_W bits iff everything from the new sign bit upward is a pure sign copy.
    always_comb begin
        top_bits = bus.In[IN_W-1:OUT_W-1];
        ovf      = !((&top_bits) || !(|top_bits));
        hi_in    = ovf && !bus.In[IN_W-1];
        lo_in    = ovf && bus.In[IN_W-1];
    end

    always_comb begin
        adv2     = !v2_q || bus.out_ready;
        in_rdy   = !v1_q || adv2;
        in_xfer  = bus.in_valid && in_rdy;
        sat_xfer = v2_q && bus.out_ready && sat2_q;
    end

    // Stage 1: low bits plus range verdict; upper bits are no longer needed once classified.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q  <= 1'b0;
            d1_q  <= '0;
            hi1_q <= 1'b0;
            lo1_q <= 1'b0;
        end else if (in_rdy) begin
            v1_q <= bus.in_valid;
            if (in_xfer) begin
                d1_q  <= bus.In[OUT_W-1:0];
                hi1_q <= hi_in;
                lo1_q <= lo_in;
            end
        end
    end

    // Stage 2: clamp or pass through; held while the consumer stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v2_q   <= 1'b0;
            out_q  <= '0;
            sat2_q <= 1'b0;
        end else if (adv2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                if (hi1_q) begin
                    out_q <= MaxVal;
                end else if (lo1_q) begin
                    out_q <= MinVal;
                end else begin
                    out_q <= d1_q;
                end
                sat2_q <= hi1_q || lo1_q;
            end
        end
    end

    // Clear takes priority over a coincident saturated delivery.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else if (bus.sat_clr) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else if (sat_xfer) begin
            sticky_q <= 1'b1;
            if (cnt_q != CntMax) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.in_ready   = in_rdy;
    assign bus.Out        = out_q;
    assign bus.out_valid  = v2_q;
    assign bus.sat        = sat2_q;
    assign bus.sat_sticky = sticky_q;
    assign bus.sat_count  = cnt_q;
endmodule
